// File: rtl/data_bus_lsu.sv
// Load/store unit bridging a CPU data port to a single-beat, ready-handshaked word bus.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned accesses complete without a bus cycle.
module data_bus_lsu #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  busWe,
  input  logic        rdEn,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        misalign
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [31:0]      rdata_reg, rdata_next;
  logic             err_reg, err_next;
  logic             misalign_reg, misalign_next;
  logic             mem_we_reg, mem_we_next;
  logic [31:0]      mem_addr_reg, mem_addr_next;
  logic [3:0]       be_reg, be_next;
  logic [31:0]      mem_wdata_reg, mem_wdata_next;
  logic [2:0]       func3_reg, func3_next;
  logic [1:0]       off_reg, off_next;
  logic             is_load_reg, is_load_next;

  logic             is_store;
  logic             misalign_det;
  logic             wait_expired;
  logic [3:0]       req_be;
  logic [31:0]      req_wdata;
  logic [31:0]      sb_data, sh_data;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;

  assign is_store     = (busWe != 2'b00);
  assign wait_expired = (32'(wait_cnt_reg) + 32'd1) >= 32'(WAIT_MAX);

  // Store data is replicated across lanes so the memory only has to honour mem_be.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign sb_data[gi*8 +: 8] = wdata[7:0];
    assign sh_data[gi*8 +: 8] = wdata[(gi % 2)*8 +: 8];
  end

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = wdata;
    case (busWe)
      2'b01: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = sb_data;
      end
      2'b10: begin
        req_be    = 4'b0011 << {addr[1], 1'b0};
        req_wdata = sh_data;
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    if (is_store)
      misalign_det = ((busWe == 2'b10) && addr[0]) ||
                     ((busWe == 2'b11) && (addr[1:0] != 2'b00));
    else
      misalign_det = (((func3 == 3'b001) || (func3 == 3'b101)) && addr[0]) ||
                     ((func3 == 3'b010) && (addr[1:0] != 2'b00));
  end
`else
  assign misalign_det = 1'b0;
`endif

  assign byte_sel = mem_rdata[{off_reg, 3'b000} +: 8];
  assign half_sel = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (func3_reg)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    misalign_next  = misalign_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    be_next        = be_reg;
    mem_wdata_next = mem_wdata_reg;
    func3_next     = func3_reg;
    off_next       = off_reg;
    is_load_next   = is_load_reg;
    case (state_reg)
      IDLE: begin
        // A simultaneous store and load resolves to the store.
        if (is_store || rdEn) begin
          func3_next     = func3;
          off_next       = addr[1:0];
          is_load_next   = !is_store;
          mem_addr_next  = {addr[31:2], 2'b00};
          mem_we_next    = is_store;
          be_next        = req_be;
          mem_wdata_next = is_store ? req_wdata : mem_wdata_reg;
          wait_cnt_next  = '0;
          if (misalign_det) begin
            state_next    = DONE;
            err_next      = 1'b0;
            misalign_next = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_next    = DONE;
          err_next      = 1'b0;
          misalign_next = 1'b0;
          if (is_load_reg)
            rdata_next = load_data;
        end else if (wait_expired) begin
          state_next    = DONE;
          err_next      = 1'b1;
          misalign_next = 1'b0;
          if (is_load_reg)
            rdata_next = 32'd0;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      rdata_reg     <= 32'd0;
      err_reg       <= 1'b0;
      misalign_reg  <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      be_reg        <= 4'd0;
      mem_wdata_reg <= 32'd0;
      func3_reg     <= 3'd0;
      off_reg       <= 2'd0;
      is_load_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      misalign_reg  <= misalign_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      be_reg        <= be_next;
      mem_wdata_reg <= mem_wdata_next;
      func3_reg     <= func3_next;
      off_reg       <= off_next;
      is_load_reg   <= is_load_next;
    end
  end

  // Bus strobes derive from the state register so reset drops them without a clock.
  assign mem_req   = (state_reg == REQ);
  assign busy      = (state_reg == REQ);
  assign done      = (state_reg == DONE);
  assign mem_be    = mem_req ? be_reg : 4'b0000;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rdata     = rdata_reg;
  assign err       = err_reg;
  assign misalign  = misalign_reg;

endmodule

// File: tb/tb_data_bus_lsu.sv
// Bench for data_bus_lsu: transaction-level model plus per-cycle output comparison.
// Honours LSU_MISALIGN_CHECK_EN when the design is built with it.
module tb_data_bus_lsu;

  localparam int WAIT_MAX = 15;

  logic        clk;
  logic        reset;
  logic [1:0]  busWe;
  logic        rdEn;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        misalign;

  data_bus_lsu #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .busWe     (busWe),
    .rdEn      (rdEn),
    .func3     (func3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state and per-cycle expectations.
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_mis;
  logic        exp_busy, exp_done, exp_req, exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata;
  logic        chk_en;

  // Observation record kept by the compare process.
  int          cycle_no = 0;
  int          busy_total = 0;
  int          req_total = 0;
  int          last_done = -1;
  logic [3:0]  seen_be;
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_we;

  int start_cyc, start_busy, start_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic set_phase(input logic b, input logic d, input logic r);
    exp_busy = b;
    exp_done = d;
    exp_req  = r;
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
        if (f3 == 3'b000 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // Inputs other than the handshake are disturbed after the request edge.
  task automatic scramble(input bit junk);
    addr  = $urandom;
    wdata = $urandom;
    func3 = 3'($urandom_range(0, 7));
    busWe = junk ? 2'($urandom_range(0, 3)) : 2'b00;
    rdEn  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic run_txn(input logic [1:0] we, input logic rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                         input int delay, input bit junk);
    bit st, ld, mis, tout;
    logic [3:0]  be;
    logic [31:0] mwd;
    @(posedge clk); #1;
    start_cyc  = cycle_no;
    start_busy = busy_total;
    start_req  = req_total;
    busWe = we; rdEn = rd; func3 = f3; addr = a; wdata = wd;
    mem_rdata = mrd; mem_ready = 1'b0;
    set_phase(1'b0, 1'b0, 1'b0);
    st = (we != 2'b00);
    ld = !st && rd;
    $display("txn we=%0d rd=%0d f3=%0d addr=0x%08h wdata=0x%08h mrd=0x%08h delay=%0d",
             we, rd, f3, a, wd, mrd, delay);
    if (!st && !ld) return;
    case (we)
      2'b01: begin be = 4'(32'd1 << a[1:0]); mwd = 32'(wd[7:0]) * 32'h0101_0101; end
      2'b10: begin be = 4'(32'd3 << (2 * int'(a[1]))); mwd = 32'(wd[15:0]) * 32'h0001_0001; end
      default: begin be = 4'hF; mwd = wd; end
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    if (st) mis = (we == 2'b10 && a[0]) || (we == 2'b11 && a[1:0] != 2'b00);
    else    mis = ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    exp_be = be; exp_addr = a & 32'hFFFF_FFFC; exp_we = st; exp_wdata = mwd;
    @(posedge clk); #1;
    scramble(junk);
    if (mis) begin
      m_mis = 1'b1; m_err = 1'b0;
      set_phase(1'b0, 1'b1, 1'b0);
      return;
    end
    tout = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      mem_ready = (i == delay);
      set_phase(1'b1, 1'b0, 1'b1);
      if (i == delay) break;
      if (i == WAIT_MAX - 1) begin tout = 1'b1; break; end
      @(posedge clk); #1;
      scramble(junk);
    end
    @(posedge clk); #1;
    scramble(junk);
    mem_ready = 1'b0;
    m_err = tout;
    m_mis = 1'b0;
    if (ld) m_rdata = tout ? 32'd0 : model_load(f3, a, mrd);
    set_phase(1'b0, 1'b1, 1'b0);
  endtask

  task automatic settle;
    @(negedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    32'(busy),    32'(exp_busy));
      check("done",    32'(done),    32'(exp_done));
      check("mem_req", 32'(mem_req), 32'(exp_req));
      check("mem_be",  32'(mem_be),  32'(exp_req ? exp_be : 4'h0));
      check("rdata",   rdata,        m_rdata);
      check("err",     32'(err),     32'(m_err));
      check("misalign", 32'(misalign), 32'(m_mis));
      if (exp_req) begin
        check("mem_addr", mem_addr, exp_addr);
        check("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
    end
    if (busy) busy_total++;
    if (mem_req) begin
      req_total++;
      seen_be = mem_be; seen_addr = mem_addr; seen_wdata = mem_wdata; seen_we = mem_we;
    end
    if (done) last_done = cycle_no;
    cycle_no++;
  end

  initial begin
    chk_en = 1'b0;
    reset = 1'b1;
    busWe = 2'b00; rdEn = 1'b0; func3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_rdata = 32'd0; mem_ready = 1'b0;
    m_rdata = 32'd0; m_err = 1'b0; m_mis = 1'b0;
    exp_be = 4'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_we = 1'b0;
    set_phase(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    run_txn(2'b01, 1'b0, 3'd0, 32'h0000_1003, 32'h0000_00AB, 32'd0, 0, 1'b0);
    settle();
    check("sb_be", 32'(seen_be), 32'h8);
    check("sb_wdata", seen_wdata, 32'hABAB_ABAB);
    check("sb_addr", seen_addr, 32'h0000_1000);
    check("sb_done_cycle", 32'(last_done - start_cyc), 32'd2);

    run_txn(2'b00, 1'b1, 3'b000, 32'h0000_2001, 32'd0, 32'h0000_F000, 0, 1'b0);
    settle();
    check("lb_rdata", rdata, 32'hFFFF_FFF0);
    run_txn(2'b00, 1'b1, 3'b100, 32'h0000_2001, 32'd0, 32'h0000_F000, 0, 1'b0);
    settle();
    check("lbu_rdata", rdata, 32'h0000_00F0);

    run_txn(2'b00, 1'b1, 3'b001, 32'h0000_2002, 32'd0, 32'h8001_0000, 3, 1'b0);
    settle();
    check("lh_busy_cycles", 32'(busy_total - start_busy), 32'd4);
    check("lh_rdata", rdata, 32'hFFFF_8001);

    run_txn(2'b10, 1'b0, 3'd0, 32'h0000_2003, 32'h1234_ABCD, 32'd0, 1, 1'b1);
    run_txn(2'b00, 1'b1, 3'b101, 32'h0000_2000, 32'd0, 32'h1234_F00D, 0, 1'b0);
    settle();
    check("lhu_rdata", rdata, 32'h0000_F00D);

    run_txn(2'b11, 1'b0, 3'd0, 32'h0000_3002, 32'hDEAD_BEEF, 32'd0, 2, 1'b0);
    settle();
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_flag", 32'(misalign), 32'd1);
    check("mis_done_cycle", 32'(last_done - start_cyc), 32'd1);
    check("mis_no_req", 32'(req_total - start_req), 32'd0);
`else
    check("sw_flag", 32'(misalign), 32'd0);
    check("sw_addr", seen_addr, 32'h0000_3000);
`endif
    check("sw_keeps_rdata", rdata, 32'h0000_F00D);

    run_txn(2'b00, 1'b1, 3'b010, 32'h0000_5004, 32'd0, 32'hCAFE_BABE, 0, 1'b1);
    run_txn(2'b00, 1'b1, 3'b010, 32'h0000_5008, 32'd0, 32'h1111_2222, 100, 1'b0);
    settle();
    check("to_busy_cycles", 32'(busy_total - start_busy), 32'd15);
    check("to_err", 32'(err), 32'd1);
    check("to_rdata", rdata, 32'd0);

    run_txn(2'b00, 1'b1, 3'b000, 32'h0000_6000, 32'd0, 32'h0000_007F, 0, 1'b0);
    settle();
    check("lb_err_clear", 32'(err), 32'd0);

    run_txn(2'b11, 1'b1, 3'b010, 32'h0000_7000, 32'h55AA_55AA, 32'hFFFF_FFFF, 0, 1'b0);
    settle();
    check("both_is_write", 32'(seen_we), 32'd1);
    check("both_rdata", rdata, 32'h0000_007F);

    run_txn(2'b00, 1'b1, 3'b011, 32'h0000_8000, 32'd0, 32'h1357_2468, 1, 1'b0);
    settle();
    check("f3_other_rdata", rdata, 32'h1357_2468);
    run_txn(2'b00, 1'b0, 3'd0, 32'h0000_9000, 32'd0, 32'd0, 0, 1'b0);

    // Abort a load in flight with reset.
    @(posedge clk); #1;
    chk_en = 1'b0;
    busWe = 2'b00; rdEn = 1'b1; func3 = 3'b010; addr = 32'h0000_4000; mem_ready = 1'b0;
    mem_rdata = 32'h1234_5678;
    $display("txn reset during REQ of LW addr=0x00004000");
    @(posedge clk); #1;
    rdEn = 1'b0;
    check("abort_req_before", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_req_async", 32'(mem_req), 32'd0);
    check("abort_be_async", 32'(mem_be), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    m_rdata = 32'd0; m_err = 1'b0; m_mis = 1'b0;
    set_phase(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    settle();
    check("abort_rdata_after", rdata, 32'd0);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_lsu.md
DATA_BUS_LSU -- requirements
Module: data_bus_lsu

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum REQ cycles without mem_ready before timeout.
REQ-002 SHALL have port clk, input, 1: clock; reset is reset, asynchronous, active-high.
REQ-003 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-004 SHALL have port busWe, input, 2: store request; 00 none, 01 SB, 10 SH, 11 SW.
REQ-005 SHALL have port rdEn, input, 1: load request strobe.
REQ-006 SHALL have port func3, input, 3: load type; 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 SHALL have ports addr (input, 32: byte address) and wdata (input, 32: store data, low-aligned).
REQ-008 SHALL have ports rdata (output, 32: extended load result), busy (output, 1: stall), done (output, 1: completion pulse) and err (output, 1: timeout flag).
REQ-009 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32, word-aligned), mem_be (output, 4) and mem_wdata (output, 32).
REQ-010 SHALL have ports mem_rdata (input, 32), mem_ready (input, 1) and misalign (output, 1).

Function
REQ-011 SHALL implement the FSM states IDLE, REQ and DONE.
REQ-012 In IDLE, at a posedge with busWe!=0 or rdEn=1, the block SHALL latch addr, wdata, func3 and the access type, then go to REQ.
REQ-013 If busWe!=0 and rdEn=1 are sampled together, the store SHALL win and the load SHALL be dropped.
REQ-014 Requests sampled outside IDLE SHALL be ignored.
REQ-015 In REQ, mem_req SHALL be 1, all mem_* outputs SHALL be held stable, and busy SHALL be 1.
REQ-016 In REQ, mem_ready=1 at a posedge SHALL move the FSM to DONE; for a load, that edge SHALL capture the extended mem_rdata into rdata.
REQ-017 A wait counter SHALL clear on entry to REQ and increment on each REQ cycle with mem_ready=0.
REQ-018 When the wait counter reaches WAIT_MAX, the FSM SHALL go to DONE with err=1 and rdata=0 for a load.
REQ-019 DONE SHALL assert done=1 for exactly one cycle with busy=0, then return to IDLE.
REQ-020 Minimum latency SHALL be: request sampled at edge 0, mem_req high in cycle 1, done high in cycle 2 when mem_ready=1 in cycle 1.
REQ-021 rdata SHALL hold its value until the next load completes; stores SHALL NOT modify rdata.
REQ-022 err SHALL be updated only on entry to DONE and SHALL hold until the next DONE.
REQ-023 mem_addr SHALL equal {addr[31:2],2'b00}, and mem_we SHALL be 1 for stores and 0 for loads.
REQ-024 Store byte lanes SHALL be:
- SB: mem_be=4'b0001<<addr[1:0], mem_wdata=wdata[7:0] replicated x4.
- SH: mem_be=4'b0011<<{addr[1],1'b0}, mem_wdata=wdata[15:0] replicated x2.
- SW: mem_be=4'b1111, mem_wdata=wdata.
REQ-025 Loads SHALL drive mem_be=4'b1111.
REQ-026 Load extraction SHALL be:
- LB/LBU: the byte at addr[1:0], sign- or zero-extended.
- LH/LHU: the halfword at addr[1], sign- or zero-extended.
- LW, and any other func3: the full word.
REQ-027 When idle or in DONE, mem_req SHALL be 0 and mem_be SHALL be 0.

Reset
REQ-028 On reset the FSM SHALL go to IDLE and all outputs SHALL clear: rdata=0, busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, misalign=0.
REQ-029 Reset asserted mid-REQ SHALL abort the access immediately: mem_req=0 asynchronously, no done pulse, and rdata unchanged from its reset value.

Configuration
REQ-030 With macro LSU_MISALIGN_CHECK_EN defined, a misaligned access SHALL skip REQ and go directly to DONE with misalign=1, mem_req never asserted, and rdata unchanged.
- Misaligned means: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0.
REQ-031 Without LSU_MISALIGN_CHECK_EN, misalign SHALL be tied 0, addr[0] SHALL be ignored for halfwords, and addr[1:0] SHALL be ignored for words.

Verification
REQ-032 SB, addr=0x1003, wdata=0x000000AB, mem_ready=1 in cycle 1 -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, done in cycle 2.
REQ-033 LB, addr=0x2001, mem_rdata=0x0000F000 -> rdata=0xFFFFFFF0; the same access as LBU -> rdata=0x000000F0.
REQ-034 LH, addr=0x2002, mem_rdata=0x80010000, mem_ready delayed 3 cycles -> busy high for 4 cycles, rdata=0xFFFF8001.
REQ-035 Load with mem_ready stuck at 0, WAIT_MAX=15 -> done after 15 REQ cycles, err=1, rdata=0.
REQ-036 busWe=11 and rdEn=1 in the same cycle -> only a write is issued (mem_we=1); reset pulse mid-REQ -> mem_req=0 immediately, no done.
REQ-037 With LSU_MISALIGN_CHECK_EN defined, SW at addr=0x3002 -> misalign=1, done in cycle 1, no mem_req.
